// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - host command byte-stream parser producing register write strobes
module uart_cmd_decoder #(
  parameter int          DATA_BIT    = 32,
  parameter int          PACK_NUM    = 4,
  parameter int          OUTPUT_NUM  = 16,
  parameter int          CH_W        = 4,
  parameter logic [7:0]  SLOW_PERIOD = 8'h14,
  parameter logic [7:0]  FAST_PERIOD = 8'h05,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  CMD_FREQ    = 8'h01,
  parameter logic [7:0]  CMD_PERIOD  = 8'h02,
  parameter logic [7:0]  CMD_DATA    = 8'h03,
  parameter logic [7:0]  CMD_CTRL    = 8'h04
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  output logic [DATA_BIT-1:0] freq_o,
  output logic                freq_we_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                period_we_o,
  output logic [CH_W-1:0]     channel_o,
  output logic [DATA_BIT-1:0] data_o,
  output logic                data_we_o,
  output logic                mode_o,
  output logic                en_o,
  output logic                ctrl_we_o,
  output logic                err_o
);

  localparam int PC_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PC_W-1:0] LAST_BYTE = PC_W'(PACK_NUM - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, FREQ_PAY, PER_SLOW, PER_FAST, DATA_CH, DATA_PAY, CTRL_CH, CTRL_BYTE
  } state_t;

  state_t              state_q;
  logic [PC_W-1:0]     byte_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [DATA_BIT-1:0] shadow_q;
  logic [CH_W-1:0]     ch_shadow_q;
  logic                ch_bad_q;

  logic [DATA_BIT-1:0] freq_q, data_q;
  logic [7:0]          slow_q, fast_q;
  logic [CH_W-1:0]     channel_q;
  logic                mode_q, en_q;
  logic                freq_we_q, period_we_q, data_we_q, ctrl_we_q, err_q;

  logic [DATA_BIT-1:0] shifted;
  logic                ch_bad_in;

  // Payload arrives LSB byte first, so each new byte enters at the top and slides down
  assign shifted   = {data_i, shadow_q[DATA_BIT-1:8]};
  assign ch_bad_in = ({24'd0, data_i} >= 32'(OUTPUT_NUM));

  // Packet FSM, inter-byte timeout, shadow assembly and registered outputs/strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      shadow_q    <= '0;
      ch_shadow_q <= '0;
      ch_bad_q    <= 1'b0;
      freq_q      <= '0;
      data_q      <= '0;
      slow_q      <= SLOW_PERIOD;
      fast_q      <= FAST_PERIOD;
      channel_q   <= '0;
      mode_q      <= 1'b0;
      en_q        <= 1'b0;
      freq_we_q   <= 1'b0;
      period_we_q <= 1'b0;
      data_we_q   <= 1'b0;
      ctrl_we_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      freq_we_q   <= 1'b0;
      period_we_q <= 1'b0;
      data_we_q   <= 1'b0;
      ctrl_we_q   <= 1'b0;
      err_q       <= 1'b0;

      // A received byte always restarts the gap timer; the timer only runs mid-packet
      if (state_q == IDLE || rx_done_tick_i) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_MAX) begin
        to_cnt_q   <= '0;
        byte_cnt_q <= '0;
        state_q    <= IDLE;
        err_q      <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (rx_done_tick_i) begin
        case (state_q)
          IDLE: begin
            byte_cnt_q <= '0;
            case (data_i)
              CMD_FREQ:   state_q <= FREQ_PAY;
              CMD_PERIOD: state_q <= PER_SLOW;
              CMD_DATA:   state_q <= DATA_CH;
              CMD_CTRL:   state_q <= CTRL_CH;
              default:    err_q   <= 1'b1;
            endcase
          end
          FREQ_PAY: begin
            shadow_q <= shifted;
            if (byte_cnt_q == LAST_BYTE) begin
              freq_q     <= shifted;
              freq_we_q  <= 1'b1;
              byte_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          PER_SLOW: begin
            shadow_q[7:0] <= data_i;
            state_q       <= PER_FAST;
          end
          PER_FAST: begin
            slow_q      <= shadow_q[7:0];
            fast_q      <= data_i;
            period_we_q <= 1'b1;
            state_q     <= IDLE;
          end
          DATA_CH, CTRL_CH: begin
            ch_shadow_q <= data_i[CH_W-1:0];
            ch_bad_q    <= ch_bad_in;
            byte_cnt_q  <= '0;
            state_q     <= (state_q == DATA_CH) ? DATA_PAY : CTRL_BYTE;
          end
          DATA_PAY: begin
            shadow_q <= shifted;
            if (byte_cnt_q == LAST_BYTE) begin
              // An out-of-range channel still consumes its payload, then reports instead of writing
              if (ch_bad_q) begin
                err_q <= 1'b1;
              end else begin
                data_q    <= shifted;
                channel_q <= ch_shadow_q;
                data_we_q <= 1'b1;
              end
              byte_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          CTRL_BYTE: begin
            if (ch_bad_q) begin
              err_q <= 1'b1;
            end else begin
              en_q      <= data_i[0];
              mode_q    <= data_i[1];
              channel_q <= ch_shadow_q;
              ctrl_we_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign freq_o        = freq_q;
  assign freq_we_o     = freq_we_q;
  assign slow_period_o = slow_q;
  assign fast_period_o = fast_q;
  assign period_we_o   = period_we_q;
  assign channel_o     = channel_q;
  assign data_o        = data_q;
  assign data_we_o     = data_we_q;
  assign mode_o        = mode_q;
  assign en_o          = en_q;
  assign ctrl_we_o     = ctrl_we_q;
  assign err_o         = err_q;

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Receive-side command parser for the serial-output controller. Consumes the host byte stream from the UART receiver (byte plus rx_done tick) and decodes the four host commands: FREQ, PERIOD, DATA and CTRL.
- Each completed packet produces one write strobe with the assembled fields. These strobes feed the frequency, period, per-channel pattern and per-channel control registers of diff_freq_serial_out.
- Detects malformed traffic (unknown command, bad channel, inter-byte timeout) and resynchronises to the next command byte.

Parameters:
- DATA_BIT, 32, width of frequency pattern and channel data pattern; must equal 8*PACK_NUM.
- PACK_NUM, 4, payload bytes per FREQ/DATA packet.
- OUTPUT_NUM, 16, number of serial channels; valid channel indices are 0..OUTPUT_NUM-1.
- CH_W, 4, width of channel_o; must satisfy 2^CH_W >= OUTPUT_NUM.
- SLOW_PERIOD, 8'h14, reset value of slow_period_o.
- FAST_PERIOD, 8'h05, reset value of fast_period_o.
- TIMEOUT_CYC, 100000, maximum clk_i cycles allowed between bytes inside a packet.
- CMD_FREQ / CMD_PERIOD / CMD_DATA / CMD_CTRL, 8'h01 / 8'h02 / 8'h03 / 8'h04, command byte codes. Top level overrides these with the `CMD_* values from user_cmd.vh.

Ports:
- clk_i, in, 1, system clock.
- rst_ni, in, 1, asynchronous active-low reset.
- data_i, in, 8, received byte; valid only while rx_done_tick_i is high.
- rx_done_tick_i, in, 1, one-cycle byte-valid strobe.
- freq_o, out, DATA_BIT, frequency select pattern (bit=1 selects fast).
- freq_we_o, out, 1, one-cycle strobe: freq_o updated.
- slow_period_o, out, 8, slow bit period.
- fast_period_o, out, 8, fast bit period.
- period_we_o, out, 1, one-cycle strobe: both periods updated.
- channel_o, out, CH_W, target channel of the last DATA/CTRL write.
- data_o, out, DATA_BIT, channel data pattern.
- data_we_o, out, 1, one-cycle strobe: data_o/channel_o valid.
- mode_o, out, 1, 0 = one-shot, 1 = repeat.
- en_o, out, 1, channel enable.
- ctrl_we_o, out, 1, one-cycle strobe: mode_o/en_o/channel_o valid.
- err_o, out, 1, one-cycle strobe on any protocol error.

Behaviour:
- Packet formats (bytes in order):
  - FREQ: CMD_FREQ, then PACK_NUM bytes, LSB byte first.
  - PERIOD: CMD_PERIOD, slow, fast.
  - DATA: CMD_DATA, channel, then PACK_NUM bytes, LSB byte first.
  - CTRL: CMD_CTRL, channel, ctrl byte. Bit0 = en, bit1 = mode, bits[7:2] are ignored.
- States: IDLE, FREQ_PAY, PER_SLOW, PER_FAST, DATA_CH, DATA_PAY, CTRL_CH, CTRL_BYTE. A byte counter (0..PACK_NUM-1) runs in the *_PAY states.
- State advances only on cycles with rx_done_tick_i=1. data_i is ignored otherwise.
- IDLE: a known command byte moves to its first state. Any other byte pulses err_o for one cycle and the FSM stays in IDLE.
- Payload is shifted into an internal shadow register. Outputs are not disturbed until the packet completes.
- Completion: on the edge that accepts the last byte, the outputs load from the shadow register. The matching *_we_o is high for exactly the following cycle (latency 1 clk after the final rx_done_tick_i). The FSM returns to IDLE on the same edge.
- Channel byte >= OUTPUT_NUM: all remaining packet bytes are still consumed. At completion no *_we_o fires, outputs keep their old values, and err_o pulses in place of the strobe.
- Timeout counter: cleared on every rx_done_tick_i and held at 0 in IDLE. If it reaches TIMEOUT_CYC-1 in a non-IDLE state, the FSM goes to IDLE, err_o pulses, the partial packet is dropped and no output changes.
- At most one of freq_we_o/period_we_o/data_we_o/ctrl_we_o/err_o is high in any cycle.
- Back-to-back packets with no idle gap are supported. A byte arriving on the cycle a strobe is high is accepted normally.
- All outputs are registered and hold their values between writes.
- Reset values:
  - freq_o=0, slow_period_o=SLOW_PERIOD, fast_period_o=FAST_PERIOD.
  - channel_o=0, data_o=0, mode_o=0, en_o=0.
  - All strobes and err_o = 0.
  - FSM=IDLE, counters=0, shadow register=0.
- Reset asserted mid-packet aborts the packet immediately. After release the FSM waits for a new command byte.

Test Plan:
- Byte ticks 01,55,55,55,55 -> freq_o=32'h5555_5555; freq_we_o high exactly one cycle, 1 clk after the 5th tick; no other strobe.
- 02,14,05 -> slow_period_o=8'h14, fast_period_o=8'h05, one period_we_o pulse. Then 03,0F,78,56,34,12 -> channel_o=15, data_o=32'h1234_5678, data_we_o pulse.
- 04,03,FE -> channel_o=3, mode_o=1, en_o=0, ctrl_we_o pulse (reserved bits ignored). Then 04,10,01 -> err_o pulse, no ctrl_we_o, channel_o stays 3.
- Byte AA in IDLE -> err_o pulse. Then 02,20,08 -> period write succeeds (resync).
- 01,11,22 then silence for TIMEOUT_CYC cycles -> err_o pulse, freq_o unchanged. Then 01,44,33,22,11 -> freq_o=32'h1122_3344.
- Full UART loop at the project baud: FREQ, PERIOD, then DATA+CTRL for channels 0..15 in one-shot/enable. Expect 16 data_we_o and 16 ctrl_we_o pulses with matching channel_o, and zero err_o. Also assert rst_ni low mid-DATA packet -> all outputs return to reset values and no strobe fires.
